// File: rtl/iob_axi_burst_ram.sv
// AXI4 burst-capable RAM slave backed by a register-array memory.
// Independent write (AW/W/B) and read (AR/R) engines; reads have one cycle
// of latency and sustain one beat per cycle. FIXED bursts hold the index,
// INCR/WRAP advance it modulo the memory depth.
module iob_axi_burst_ram #(
    parameter int AXI_ID_W   = 1,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ADDR_W = 24,
    parameter int AXI_DATA_W = 32,
    parameter int MEM_ADDR_W = 10
) (
    input  logic                    clk_i,
    input  logic                    arst_i,
    input  logic                    cke_i,
    input  logic [AXI_ID_W-1:0]     axi_awid_i,
    input  logic [AXI_ADDR_W-1:0]   axi_awaddr_i,
    input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
    input  logic [1:0]              axi_awburst_i,
    input  logic                    axi_awvalid_i,
    output logic                    axi_awready_o,
    input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
    input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
    input  logic                    axi_wlast_i,
    input  logic                    axi_wvalid_i,
    output logic                    axi_wready_o,
    output logic [AXI_ID_W-1:0]     axi_bid_o,
    output logic [1:0]              axi_bresp_o,
    output logic                    axi_bvalid_o,
    input  logic                    axi_bready_i,
    input  logic [AXI_ID_W-1:0]     axi_arid_i,
    input  logic [AXI_ADDR_W-1:0]   axi_araddr_i,
    input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
    input  logic [1:0]              axi_arburst_i,
    input  logic                    axi_arvalid_i,
    output logic                    axi_arready_o,
    output logic [AXI_ID_W-1:0]     axi_rid_o,
    output logic [AXI_DATA_W-1:0]   axi_rdata_o,
    output logic [1:0]              axi_rresp_o,
    output logic                    axi_rlast_o,
    output logic                    axi_rvalid_o,
    input  logic                    axi_rready_i
);

    localparam int DEPTH  = 2 ** MEM_ADDR_W;
    localparam int STRB_W = AXI_DATA_W / 8;

    localparam logic [MEM_ADDR_W-1:0] IDX_ONE = {{(MEM_ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [AXI_LEN_W-1:0]  CNT_ONE = {{(AXI_LEN_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [AXI_DATA_W-1:0] mem [DEPTH];

    w_state_t              w_state;
    logic [MEM_ADDR_W-1:0] w_idx;
    logic [AXI_LEN_W-1:0]  w_len;
    logic [AXI_LEN_W-1:0]  w_cnt;
    logic [1:0]            w_burst;
    logic [AXI_ID_W-1:0]   w_id;

    r_state_t              r_state;
    logic [MEM_ADDR_W-1:0] r_idx;
    logic [AXI_LEN_W-1:0]  r_len;
    logic [AXI_LEN_W-1:0]  r_cnt;
    logic [1:0]            r_burst;

    // Word index from a byte address; bits above the memory range alias.
    logic [MEM_ADDR_W-1:0] aw_idx, ar_idx, r_nidx;
    logic [AXI_LEN_W-1:0]  r_cnt_nxt;
    logic aw_fire, w_fire, b_fire, ar_fire, r_fire;

    // Address LSBs, high aliasing bits and wlast carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{axi_awaddr_i, axi_araddr_i, axi_wlast_i};

    function automatic logic [MEM_ADDR_W-1:0] next_idx(
        input logic [MEM_ADDR_W-1:0] idx,
        input logic [1:0]            burst
    );
        return (burst == 2'b00) ? idx : idx + IDX_ONE;
    endfunction

    assign aw_idx    = axi_awaddr_i[MEM_ADDR_W+1:2];
    assign ar_idx    = axi_araddr_i[MEM_ADDR_W+1:2];
    assign r_nidx    = next_idx(r_idx, r_burst);
    assign r_cnt_nxt = r_cnt + CNT_ONE;

    // Ready signals are masked by cke so a frozen slave never shows a handshake.
    assign axi_awready_o = cke_i && (w_state == W_IDLE);
    assign axi_wready_o  = cke_i && (w_state == W_DATA);
    assign axi_arready_o = cke_i && (r_state == R_IDLE);
    assign axi_bresp_o   = 2'b00;
    assign axi_rresp_o   = 2'b00;

    assign aw_fire = axi_awready_o && axi_awvalid_i;
    assign w_fire  = axi_wready_o && axi_wvalid_i;
    assign b_fire  = cke_i && axi_bvalid_o && axi_bready_i;
    assign ar_fire = axi_arready_o && axi_arvalid_i;
    assign r_fire  = cke_i && axi_rvalid_o && axi_rready_i;

    // Byte-enabled memory write; no reset so contents survive arst_i.
    always_ff @(posedge clk_i) begin
        if (w_fire) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (axi_wstrb_i[b]) mem[w_idx][8*b +: 8] <= axi_wdata_i[8*b +: 8];
            end
        end
    end

    // Write engine: accept address, count beats, then hold the response.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            w_state      <= W_IDLE;
            w_idx        <= '0;
            w_len        <= '0;
            w_cnt        <= '0;
            w_burst      <= 2'b00;
            w_id         <= '0;
            axi_bid_o    <= '0;
            axi_bvalid_o <= 1'b0;
        end else if (cke_i) begin
            case (w_state)
                W_IDLE: if (aw_fire) begin
                    w_id    <= axi_awid_i;
                    w_idx   <= aw_idx;
                    w_len   <= axi_awlen_i;
                    w_burst <= axi_awburst_i;
                    w_cnt   <= '0;
                    w_state <= W_DATA;
                end
                W_DATA: if (w_fire) begin
                    w_idx <= next_idx(w_idx, w_burst);
                    w_cnt <= w_cnt + CNT_ONE;
                    // Beat count, not wlast, closes the burst.
                    if (w_cnt == w_len) begin
                        w_state      <= W_RESP;
                        axi_bid_o    <= w_id;
                        axi_bvalid_o <= 1'b1;
                    end
                end
                W_RESP: if (b_fire) begin
                    w_state      <= W_IDLE;
                    axi_bvalid_o <= 1'b0;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read engine: fetch the start word on AR, then the next word on each
    // accepted beat; non-blocking reads give pre-write data on collisions.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state      <= R_IDLE;
            r_idx        <= '0;
            r_len        <= '0;
            r_cnt        <= '0;
            r_burst      <= 2'b00;
            axi_rid_o    <= '0;
            axi_rdata_o  <= '0;
            axi_rlast_o  <= 1'b0;
            axi_rvalid_o <= 1'b0;
        end else if (cke_i) begin
            case (r_state)
                R_IDLE: if (ar_fire) begin
                    r_idx        <= ar_idx;
                    r_len        <= axi_arlen_i;
                    r_burst      <= axi_arburst_i;
                    r_cnt        <= '0;
                    axi_rid_o    <= axi_arid_i;
                    axi_rdata_o  <= mem[ar_idx];
                    axi_rlast_o  <= (axi_arlen_i == '0);
                    axi_rvalid_o <= 1'b1;
                    r_state      <= R_DATA;
                end
                R_DATA: if (r_fire) begin
                    if (r_cnt == r_len) begin
                        axi_rvalid_o <= 1'b0;
                        axi_rlast_o  <= 1'b0;
                        r_state      <= R_IDLE;
                    end else begin
                        r_idx       <= r_nidx;
                        r_cnt       <= r_cnt_nxt;
                        axi_rdata_o <= mem[r_nidx];
                        axi_rlast_o <= (r_cnt_nxt == r_len);
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_axi_burst_ram.sv
// Directed bench for iob_axi_burst_ram: bursts, strobes, index wrap,
// read stalls with a concurrent write, mid-burst reset and clock enable.
module tb_iob_axi_burst_ram;

    logic        clk_i = 1'b0;
    logic        arst_i, cke_i;
    logic [0:0]  axi_awid_i, axi_arid_i, axi_bid_o, axi_rid_o;
    logic [23:0] axi_awaddr_i, axi_araddr_i;
    logic [7:0]  axi_awlen_i, axi_arlen_i;
    logic [1:0]  axi_awburst_i, axi_arburst_i, axi_bresp_o, axi_rresp_o;
    logic        axi_awvalid_i, axi_awready_o, axi_wlast_i, axi_wvalid_i, axi_wready_o;
    logic [31:0] axi_wdata_i, axi_rdata_o;
    logic [3:0]  axi_wstrb_i;
    logic        axi_bvalid_o, axi_bready_i, axi_arvalid_i, axi_arready_o;
    logic        axi_rlast_o, axi_rvalid_o, axi_rready_i;

    int total = 0;
    int bad   = 0;

    logic [31:0] rd_data [16];
    logic        rd_last [16];
    logic [0:0]  rd_id;

    iob_axi_burst_ram dut (
        .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i),
        .axi_awid_i(axi_awid_i), .axi_awaddr_i(axi_awaddr_i), .axi_awlen_i(axi_awlen_i),
        .axi_awburst_i(axi_awburst_i), .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o),
        .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i), .axi_wlast_i(axi_wlast_i),
        .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o),
        .axi_bid_o(axi_bid_o), .axi_bresp_o(axi_bresp_o), .axi_bvalid_o(axi_bvalid_o),
        .axi_bready_i(axi_bready_i),
        .axi_arid_i(axi_arid_i), .axi_araddr_i(axi_araddr_i), .axi_arlen_i(axi_arlen_i),
        .axi_arburst_i(axi_arburst_i), .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o),
        .axi_rid_o(axi_rid_o), .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o),
        .axi_rlast_o(axi_rlast_o), .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i)
    );

    always #5 clk_i = ~clk_i;

    // All stimulus tasks start and end on a falling edge.
    task automatic timeout(input string what);
        total++; bad++;
        $display("FAIL timeout_%s: handshake never seen, required within bound", what);
    endtask

    task automatic aw_send(input logic [0:0] id, input logic [23:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        int t = 0;
        axi_awid_i = id; axi_awaddr_i = addr; axi_awlen_i = len; axi_awburst_i = burst;
        axi_awvalid_i = 1'b1;
        while (!axi_awready_o && t < 50) begin @(negedge clk_i); t++; end
        if (t == 50) timeout("aw");
        @(negedge clk_i);
        axi_awvalid_i = 1'b0;
    endtask

    task automatic ar_send(input logic [0:0] id, input logic [23:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        int t = 0;
        axi_arid_i = id; axi_araddr_i = addr; axi_arlen_i = len; axi_arburst_i = burst;
        axi_arvalid_i = 1'b1;
        while (!axi_arready_o && t < 50) begin @(negedge clk_i); t++; end
        if (t == 50) timeout("ar");
        @(negedge clk_i);
        axi_arvalid_i = 1'b0;
    endtask

    task automatic write_burst(input logic [0:0] id, input logic [23:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input logic [3:0] strb, input logic [31:0] base);
        aw_send(id, addr, len, burst);
        for (int i = 0; i <= int'(len); i++) begin
            int t = 0;
            axi_wvalid_i = 1'b1; axi_wdata_i = base + i; axi_wstrb_i = strb;
            axi_wlast_i = (i == int'(len));
            while (!axi_wready_o && t < 50) begin @(negedge clk_i); t++; end
            if (t == 50) timeout("w");
            @(negedge clk_i);
        end
        axi_wvalid_i = 1'b0; axi_wlast_i = 1'b0;
    endtask

    task automatic b_accept();
        int t = 0;
        axi_bready_i = 1'b1;
        while (!axi_bvalid_o && t < 50) begin @(negedge clk_i); t++; end
        if (t == 50) timeout("b");
        @(negedge clk_i);
        axi_bready_i = 1'b0;
    endtask

    // Collects beats into rd_data/rd_last; toggle stalls every other cycle.
    task automatic read_burst(input logic [0:0] id, input logic [23:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input bit toggle,
                              output int n, output bit first_ok, output int stall_bad, output int cycles);
        bit held_v = 1'b0;
        logic [31:0] held_d = '0;
        logic held_l = 1'b0;
        int k = 0;
        n = 0; stall_bad = 0; cycles = 0;
        ar_send(id, addr, len, burst);
        first_ok = (axi_rvalid_o === 1'b1);
        while (n < int'(len) + 1 && cycles < 200) begin
            axi_rready_i = toggle ? (k % 2 == 1) : 1'b1;
            if (held_v && axi_rvalid_o && (axi_rdata_o !== held_d || axi_rlast_o !== held_l))
                stall_bad++;
            if (axi_rvalid_o && axi_rready_i) begin
                if (n < 16) begin rd_data[n] = axi_rdata_o; rd_last[n] = axi_rlast_o; end
                rd_id = axi_rid_o; n++; held_v = 1'b0;
            end else if (axi_rvalid_o) begin
                held_v = 1'b1; held_d = axi_rdata_o; held_l = axi_rlast_o;
            end
            @(negedge clk_i); cycles++; k++;
        end
        if (cycles == 200) timeout("r");
        axi_rready_i = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++; if (axi_awready_o !== 1'b1) begin bad++; $display("FAIL reset_awready got=%0h exp=1", axi_awready_o); end
        total++; if (axi_wready_o !== 1'b0) begin bad++; $display("FAIL reset_wready got=%0h exp=0", axi_wready_o); end
        total++; if (axi_bvalid_o !== 1'b0) begin bad++; $display("FAIL reset_bvalid got=%0h exp=0", axi_bvalid_o); end
        total++; if (axi_arready_o !== 1'b1) begin bad++; $display("FAIL reset_arready got=%0h exp=1", axi_arready_o); end
        total++; if (axi_rvalid_o !== 1'b0 || axi_rlast_o !== 1'b0) begin bad++; $display("FAIL reset_rvalid_rlast got=%0h/%0h exp=0/0", axi_rvalid_o, axi_rlast_o); end
        total++; if (axi_rdata_o !== 32'h0 || axi_rid_o !== 1'b0 || axi_bid_o !== 1'b0) begin bad++; $display("FAIL reset_regs got rdata=%0h rid=%0h bid=%0h exp=0", axi_rdata_o, axi_rid_o, axi_bid_o); end
        @(negedge clk_i);
        arst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_incr_write();
        write_burst(1'b1, 24'h10, 8'd3, 2'b01, 4'hF, 32'hA0);
        total++; if (axi_bvalid_o !== 1'b1) begin bad++; $display("FAIL incr_wr_bvalid got=%0h exp=1", axi_bvalid_o); end
        total++; if (axi_bresp_o !== 2'b00) begin bad++; $display("FAIL incr_wr_bresp got=%0h exp=0", axi_bresp_o); end
        total++; if (axi_bid_o !== 1'b1) begin bad++; $display("FAIL incr_wr_bid got=%0h exp=1", axi_bid_o); end
        total++; if (axi_wready_o !== 1'b0 || axi_awready_o !== 1'b0) begin bad++; $display("FAIL incr_wr_resp_readies got=%0h/%0h exp=0/0", axi_wready_o, axi_awready_o); end
        b_accept();
        total++; if (axi_bvalid_o !== 1'b0 || axi_awready_o !== 1'b1) begin bad++; $display("FAIL incr_wr_after_b got bvalid=%0h awready=%0h exp=0/1", axi_bvalid_o, axi_awready_o); end
    endtask

    task automatic test_incr_read();
        int n, sb, cy; bit fo;
        read_burst(1'b1, 24'h10, 8'd3, 2'b01, 1'b0, n, fo, sb, cy);
        total++; if (fo !== 1'b1) begin bad++; $display("FAIL incr_rd_latency got=%0h exp=1", fo); end
        total++; if (n != 4 || cy != 4) begin bad++; $display("FAIL incr_rd_beats got=%0d/%0d exp=4/4", n, cy); end
        total++; if (rd_id !== 1'b1) begin bad++; $display("FAIL incr_rd_rid got=%0h exp=1", rd_id); end
        for (int i = 0; i < 4; i++) begin
            total++; if (rd_data[i] !== 32'hA0 + i || rd_last[i] !== (i == 3)) begin bad++; $display("FAIL incr_rd_beat%0d got=%0h/%0h exp=%0h/%0h", i, rd_data[i], rd_last[i], 32'hA0 + i, (i == 3)); end
        end
        total++; if (axi_rvalid_o !== 1'b0 || axi_arready_o !== 1'b1) begin bad++; $display("FAIL incr_rd_end got rvalid=%0h arready=%0h exp=0/1", axi_rvalid_o, axi_arready_o); end
    endtask

    task automatic test_partial();
        int n, sb, cy; bit fo;
        write_burst(1'b0, 24'h40, 8'd0, 2'b01, 4'hF, 32'h11223344); b_accept();
        write_burst(1'b0, 24'h40, 8'd0, 2'b01, 4'h2, 32'h0000BB00); b_accept();
        read_burst(1'b0, 24'h40, 8'd0, 2'b01, 1'b0, n, fo, sb, cy);
        total++; if (rd_data[0] !== 32'h1122BB44 || rd_last[0] !== 1'b1) begin bad++; $display("FAIL partial_strobe got=%0h/%0h exp=1122bb44/1", rd_data[0], rd_last[0]); end
    endtask

    task automatic test_wrap();
        int n, sb, cy; bit fo;
        // INCR from the last word rolls over to word 0.
        write_burst(1'b0, 24'hFFC, 8'd1, 2'b01, 4'hF, 32'h55); b_accept();
        read_burst(1'b0, 24'hFFC, 8'd1, 2'b01, 1'b0, n, fo, sb, cy);
        total++; if (rd_data[0] !== 32'h55 || rd_data[1] !== 32'h56) begin bad++; $display("FAIL wrap_incr got=%0h,%0h exp=55,56", rd_data[0], rd_data[1]); end
        read_burst(1'b0, 24'h1000, 8'd0, 2'b01, 1'b0, n, fo, sb, cy);
        total++; if (rd_data[0] !== 32'h56) begin bad++; $display("FAIL wrap_alias got=%0h exp=56", rd_data[0]); end
        // FIXED keeps one word; last beat wins.
        write_burst(1'b0, 24'h80, 8'd3, 2'b00, 4'hF, 32'hC0); b_accept();
        read_burst(1'b0, 24'h80, 8'd2, 2'b00, 1'b0, n, fo, sb, cy);
        for (int i = 0; i < 3; i++) begin
            total++; if (rd_data[i] !== 32'hC3 || rd_last[i] !== (i == 2)) begin bad++; $display("FAIL fixed_beat%0d got=%0h/%0h exp=c3/%0h", i, rd_data[i], rd_last[i], (i == 2)); end
        end
        // WRAP burst type advances like INCR.
        write_burst(1'b1, 24'h30, 8'd1, 2'b10, 4'hF, 32'h77); b_accept();
        read_burst(1'b0, 24'h30, 8'd1, 2'b01, 1'b0, n, fo, sb, cy);
        total++; if (rd_data[0] !== 32'h77 || rd_data[1] !== 32'h78) begin bad++; $display("FAIL wrap_type got=%0h,%0h exp=77,78", rd_data[0], rd_data[1]); end
    endtask

    task automatic test_stall_concurrent();
        int n, sb, cy, n2, sb2, cy2; bit fo, fo2;
        logic wb_bvalid; logic [0:0] wb_bid;
        write_burst(1'b0, 24'h20, 8'd3, 2'b01, 4'hF, 32'hD0); b_accept();
        fork
            read_burst(1'b0, 24'h20, 8'd3, 2'b01, 1'b1, n, fo, sb, cy);
            begin
                write_burst(1'b1, 24'h200, 8'd3, 2'b01, 4'hF, 32'hE0);
                wb_bvalid = axi_bvalid_o; wb_bid = axi_bid_o;
                b_accept();
            end
        join
        total++; if (n != 4 || sb != 0 || cy <= 4) begin bad++; $display("FAIL stall_rd got beats=%0d unstable=%0d cycles=%0d exp 4/0/>4", n, sb, cy); end
        for (int i = 0; i < 4; i++) begin
            total++; if (rd_data[i] !== 32'hD0 + i || rd_last[i] !== (i == 3)) begin bad++; $display("FAIL stall_beat%0d got=%0h/%0h exp=%0h/%0h", i, rd_data[i], rd_last[i], 32'hD0 + i, (i == 3)); end
        end
        total++; if (wb_bvalid !== 1'b1 || wb_bid !== 1'b1) begin bad++; $display("FAIL concurrent_wr_b got=%0h/%0h exp=1/1", wb_bvalid, wb_bid); end
        read_burst(1'b0, 24'h200, 8'd3, 2'b01, 1'b0, n2, fo2, sb2, cy2);
        for (int i = 0; i < 4; i++) begin
            total++; if (rd_data[i] !== 32'hE0 + i) begin bad++; $display("FAIL concurrent_wr_word%0d got=%0h exp=%0h", i, rd_data[i], 32'hE0 + i); end
        end
    endtask

    task automatic test_reset_mid();
        int n, sb, cy; bit fo;
        aw_send(1'b0, 24'h100, 8'd3, 2'b01);
        for (int i = 0; i < 2; i++) begin
            int t = 0;
            axi_wvalid_i = 1'b1; axi_wdata_i = 32'hF0 + i; axi_wstrb_i = 4'hF;
            while (!axi_wready_o && t < 50) begin @(negedge clk_i); t++; end
            if (t == 50) timeout("w_mid");
            @(negedge clk_i);
        end
        axi_wvalid_i = 1'b0;
        #1 arst_i = 1'b1;
        #2 arst_i = 1'b0;
        #1;
        total++; if (axi_awready_o !== 1'b1 || axi_wready_o !== 1'b0) begin bad++; $display("FAIL midrst_readies got aw=%0h w=%0h exp=1/0", axi_awready_o, axi_wready_o); end
        total++; if (axi_bvalid_o !== 1'b0) begin bad++; $display("FAIL midrst_bvalid got=%0h exp=0", axi_bvalid_o); end
        @(negedge clk_i);
        read_burst(1'b0, 24'h100, 8'd1, 2'b01, 1'b0, n, fo, sb, cy);
        total++; if (rd_data[0] !== 32'hF0 || rd_data[1] !== 32'hF1) begin bad++; $display("FAIL midrst_persist got=%0h,%0h exp=f0,f1", rd_data[0], rd_data[1]); end
    endtask

    task automatic test_cke();
        // Address offered while frozen must not be accepted.
        cke_i = 1'b0;
        axi_awid_i = 1'b0; axi_awaddr_i = 24'h300; axi_awlen_i = 8'd0; axi_awburst_i = 2'b01;
        axi_awvalid_i = 1'b1;
        repeat (3) @(negedge clk_i);
        axi_awvalid_i = 1'b0; cke_i = 1'b1;
        #1;
        total++; if (axi_wready_o !== 1'b0 || axi_awready_o !== 1'b1) begin bad++; $display("FAIL cke_aw_blocked got w=%0h aw=%0h exp=0/1", axi_wready_o, axi_awready_o); end
        @(negedge clk_i);
        // Read beat held through a frozen stretch, then resumes without loss.
        ar_send(1'b0, 24'h10, 8'd3, 2'b01);
        cke_i = 1'b0; axi_rready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        total++; if (axi_rvalid_o !== 1'b1 || axi_rdata_o !== 32'hA0 || axi_rlast_o !== 1'b0) begin bad++; $display("FAIL cke_rd_freeze got=%0h/%0h/%0h exp=1/a0/0", axi_rvalid_o, axi_rdata_o, axi_rlast_o); end
        cke_i = 1'b1;
        @(negedge clk_i);
        total++; if (axi_rdata_o !== 32'hA1) begin bad++; $display("FAIL cke_rd_resume got=%0h exp=a1", axi_rdata_o); end
        repeat (3) @(negedge clk_i);
        axi_rready_i = 1'b0;
        total++; if (axi_rvalid_o !== 1'b0) begin bad++; $display("FAIL cke_rd_drain got=%0h exp=0", axi_rvalid_o); end
    endtask

    initial begin
        arst_i = 1'b1; cke_i = 1'b1;
        axi_awid_i = '0; axi_awaddr_i = '0; axi_awlen_i = '0; axi_awburst_i = '0; axi_awvalid_i = 1'b0;
        axi_wdata_i = '0; axi_wstrb_i = '0; axi_wlast_i = 1'b0; axi_wvalid_i = 1'b0; axi_bready_i = 1'b0;
        axi_arid_i = '0; axi_araddr_i = '0; axi_arlen_i = '0; axi_arburst_i = '0; axi_arvalid_i = 1'b0;
        axi_rready_i = 1'b0;
        test_reset();
        test_incr_write();
        test_incr_read();
        test_partial();
        test_wrap();
        test_stall_concurrent();
        test_reset_mid();
        test_cke();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iob_axi_burst_ram.md
IOB_AXI_BURST_RAM -- requirements
Module: iob_axi_burst_ram

Interface
REQ-001 SHALL have parameter AXI_ID_W, default 1: ID width.
REQ-002 SHALL have parameter AXI_LEN_W, default 8: burst length width.
REQ-003 SHALL have parameter AXI_ADDR_W, default 24: byte address width.
REQ-004 SHALL have parameter AXI_DATA_W, default 32: data width.
REQ-005 SHALL have parameter MEM_ADDR_W, default 10: word address width; depth 2**MEM_ADDR_W words.
REQ-006 SHALL have ports (one clock; reset asynchronous, active-high):
- clk_i  in  1  clock
- arst_i  in  1  asynchronous active-high reset
- cke_i  in  1  clock enable; when 0, all state holds
- axi_awid_i  in  AXI_ID_W  write ID
- axi_awaddr_i  in  AXI_ADDR_W  write byte address
- axi_awlen_i  in  AXI_LEN_W  beats minus 1
- axi_awburst_i  in  2  burst type
- axi_awvalid_i / axi_awready_o  in/out  1  AW handshake
- axi_wdata_i  in  AXI_DATA_W  write data
- axi_wstrb_i  in  AXI_DATA_W/8  byte enables
- axi_wlast_i  in  1  last beat (ignored)
- axi_wvalid_i / axi_wready_o  in/out  1  W handshake
- axi_bid_o  out  AXI_ID_W  response ID
- axi_bresp_o  out  2  always 2'b00
- axi_bvalid_o / axi_bready_i  out/in  1  B handshake
- axi_arid_i, axi_araddr_i, axi_arlen_i, axi_arburst_i  in  as AW  read request
- axi_arvalid_i / axi_arready_o  in/out  1  AR handshake
- axi_rid_o  out  AXI_ID_W  read ID
- axi_rdata_o  out  AXI_DATA_W  read data
- axi_rresp_o  out  2  always 2'b00
- axi_rlast_o  out  1  last read beat
- axi_rvalid_o / axi_rready_i  out/in  1  R handshake

Function
REQ-007 SHALL hold a register-array memory of 2**MEM_ADDR_W words, not reset; word index = byte address bits [MEM_ADDR_W+1:2], higher bits ignored (aliasing).
REQ-008 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE, wready=1 only in W_DATA, bvalid=1 only in W_RESP.
REQ-009 AW handshake in W_IDLE SHALL latch id, word index, len, burst, clear beat counter, go to W_DATA next cycle.
REQ-010 Each W handshake SHALL write the bytes enabled by wstrb at the current index; the counter then increments.
REQ-011 Index SHALL increment by 1 per beat, modulo depth, for INCR (2'b01) and WRAP (2'b10); it SHALL stay fixed for FIXED (2'b00).
REQ-012 Beat count awlen+1 SHALL end W_DATA regardless of wlast; next state W_RESP with bid = latched ID.
REQ-013 B handshake SHALL return to W_IDLE; bvalid SHALL hold until bready.
REQ-014 Read FSM SHALL have states R_IDLE, R_DATA; arready=1 only in R_IDLE.
REQ-015 AR handshake SHALL latch id, index, len, burst; rvalid SHALL rise the next cycle with data at the start index (1-cycle latency).
REQ-016 rdata, rid, rlast SHALL stay stable while rvalid=1 and rready=0.
REQ-017 On R handshake with beats remaining, the next beat SHALL be presented the following cycle (one beat per cycle at full throughput); rlast=1 exactly on beat arlen.
REQ-018 R handshake on the rlast beat SHALL return to R_IDLE; rvalid=0 the next cycle.
REQ-019 Read and write FSMs SHALL operate independently and concurrently.
REQ-020 If a read beat fetch and a write target the same word in the same cycle, the read SHALL return the pre-write value.
REQ-021 cke_i=0 SHALL freeze FSMs, counters, registered outputs and memory writes; handshakes SHALL NOT complete.

Reset
REQ-022 arst_i=1 SHALL asynchronously force W_IDLE, R_IDLE, counters 0, bvalid=0, rvalid=0, rlast=0, bid=0, rid=0, rdata=0; memory contents SHALL be unaffected.
REQ-023 Reset mid-burst SHALL abandon the burst with no response; the memory retains beats already written.

Verification
REQ-024 INCR write awaddr=0x10, awlen=3, data 0xA0..0xA3, wstrb=0xF -> bvalid after 4th beat, bresp=00, bid=awid; words 4..7 hold 0xA0..0xA3.
REQ-025 INCR read araddr=0x10, arlen=3, rready=1 -> rvalid one cycle after AR, 4 consecutive beats 0xA0..0xA3, rlast on 4th only.
REQ-026 Partial write wstrb=0x2, data 0x0000BB00 over word 0x11223344 -> read 0x1122BB44.
REQ-027 Index wrap: INCR burst from last word with len=1 -> 2nd beat hits word 0; FIXED burst len=3 -> all beats hit one word, last data stored.
REQ-028 rready toggled 1/0 during 4-beat read -> data held stable while stalled, no beat lost or duplicated; concurrent write to other words completes.
REQ-029 arst_i pulse during W_DATA after 2 of 4 beats -> awready=1 and bvalid=0 after reset; the 2 written words persist.
